// File: rtl/pipe_hazard_ctrl.sv
// Purpose: hazard/sequencing control for the F/D, D/E, E/M, M/W pipeline registers plus MEM-stage wait-state FSM.
// Latency: stall/flush/forward/mem_req are combinational from state and inputs (zero added cycles).
// Backpressure: a data-memory access waiting on mem_ack freezes F..M and bubbles W until ack (or forever once timed out).
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemAccessM,
  input  logic             BranchTakenE,
  input  logic             mem_ack,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  // Wide enough to hold TIMEOUT-1, the last WAIT count before giving up.
  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  // R15 is the PC; it is never a forwarding or load-use dependency.
  localparam logic [3:0] PC_REG = 4'hF;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WCW-1:0]   r_wait_cnt;
  logic [WCW-1:0]   w_wait_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cycles;

  logic             w_mem_stall;
  logic             w_mem_req;
  logic             w_ld_stall;
  logic             w_ld_act;
  logic             w_branch_act;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // Forward select for one E-stage source: M stage is younger, so it wins over W.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic       rw_m,
    input logic [3:0] wa_m,
    input logic       rw_w,
    input logic [3:0] wa_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != PC_REG) begin
      if (rw_m && (ra == wa_m)) begin
        sel = 2'b10;
      end else if (rw_w && (ra == wa_w)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // Memory wait-state FSM and wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next-state, memory request and memory stall decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_stall    = 1'b0;
    w_mem_req      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mem_req = MemAccessM;
        // An access acked in its first cycle never stalls the pipe.
        if (MemAccessM && !mem_ack) begin
          w_mem_stall    = 1'b1;
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = WCW'(1);
        end
      end
      S_WAIT: begin
        w_mem_req = 1'b1;
        if (mem_ack) begin
          // Ack releases the stall in the same cycle it arrives.
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = '0;
        end else begin
          w_mem_stall = 1'b1;
          if (r_wait_cnt == WCW'(TIMEOUT - 1)) begin
            w_state_nxt    = S_ERR;
            w_wait_cnt_nxt = '0;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
          end
        end
      end
      S_ERR: begin
        // Dead memory: keep the pipe frozen until reset, stop requesting.
        w_mem_stall = 1'b1;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Load-use, branch and forwarding decode.
  always_comb begin
    w_ld_stall = MemtoRegE && RegWriteE && (WA3E != PC_REG) &&
                 ((WA3E == RA1D) || (WA3E == RA2D));
    // A taken branch is held while memory stalls and acts on the release cycle.
    w_branch_act = BranchTakenE && !w_mem_stall;
    // The D instruction is wrong-path when a branch is taken, so no load-use stall then.
    w_ld_act     = w_ld_stall && !w_mem_stall && !BranchTakenE;
    w_fwd_a      = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    w_fwd_b      = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
  end

  // Output drive; everything is held low during the reset cycle.
  always_comb begin
    ForwardAE    = 2'b00;
    ForwardBE    = 2'b00;
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushW       = 1'b0;
    mem_req      = 1'b0;
    mem_err      = 1'b0;
    stall_cycles = '0;
    if (!reset) begin
      ForwardAE    = w_fwd_a;
      ForwardBE    = w_fwd_b;
      StallF       = w_mem_stall || w_ld_act;
      StallD       = w_mem_stall || w_ld_act;
      StallE       = w_mem_stall;
      StallM       = w_mem_stall;
      // Flushing D/E during a memory stall would kill a held branch in E.
      FlushD       = w_branch_act;
      FlushE       = w_branch_act || w_ld_act;
      FlushW       = w_mem_stall;
      mem_req      = w_mem_req;
      mem_err      = (r_state == S_ERR);
      stall_cycles = r_stall_cycles;
    end
  end

  // Saturating count of memory-stall (StallM) cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_mem_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

endmodule
